// File: rtl/parking_lot_occupancy.sv
// parking_lot_occupancy
//   Consumes enter/exit/error pulses from the gate-sensor FSM. Keeps the lot
//   occupancy as a binary count and as a parallel 3-digit BCD count for the
//   display, raises full/empty, sticky overflow/underflow, and a saturating
//   sensor-error counter with an alarm threshold.
// Ports
//   iCLK, iRESET        clock, asynchronous active-high reset
//   iENTER/iEXIT        1-cycle pulses, one car in / one car out
//   iERROR              1-cycle pulse, sensor sequence error
//   iCLEAR              sync clear of sticky flags and error count
//   oCOUNT, oBCD        occupancy, binary and BCD {hundreds,tens,ones}
//   oFULL, oEMPTY       occupancy == CAPACITY / == 0
//   oOVERFLOW           sticky, enter seen while full
//   oUNDERFLOW          sticky, exit seen while empty
//   oERR_COUNT, oALARM  saturating error count, count >= ERR_THRESH

// One BCD digit of the up/down display counter. Carry/borrow into the next
// digit is decoded in the parent from this digit's value.
module bcdDigit (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iInc,
  input  logic       iDec,
  output logic [3:0] oDigit
);
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)    oDigit <= 4'd0;
    else if (iInc) oDigit <= (oDigit == 4'd9) ? 4'd0 : oDigit + 4'd1;
    else if (iDec) oDigit <= (oDigit == 4'd0) ? 4'd9 : oDigit - 4'd1;
  end
endmodule

module parking_lot_occupancy #(
  parameter int CAPACITY   = 200,
  parameter int CW         = 8,
  parameter int ERR_W      = 8,
  parameter int ERR_THRESH = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iENTER,
  input  logic             iEXIT,
  input  logic             iERROR,
  input  logic             iCLEAR,
  output logic [CW-1:0]    oCOUNT,
  output logic [11:0]      oBCD,
  output logic             oFULL,
  output logic             oEMPTY,
  output logic             oOVERFLOW,
  output logic             oUNDERFLOW,
  output logic [ERR_W-1:0] oERR_COUNT,
  output logic             oALARM
);
  localparam logic [CW-1:0]    CAP     = CW'(CAPACITY);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [31:0]      THR     = 32'(ERR_THRESH);

  // Simultaneous enter+exit is a net zero move: neither steps nor flags.
  logic onlyIn, onlyOut, up, dn, ovfSet, unfSet;
  assign onlyIn  = iENTER & ~iEXIT;
  assign onlyOut = iEXIT & ~iENTER;
  assign up      = onlyIn  & ~oFULL;
  assign dn      = onlyOut & ~oEMPTY;
  assign ovfSet  = onlyIn  & oFULL;
  assign unfSet  = onlyOut & oEMPTY;

  assign oFULL  = (oCOUNT == CAP);
  assign oEMPTY = (oCOUNT == '0);
  assign oALARM = (32'(oERR_COUNT) >= THR);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)  oCOUNT <= '0;
    else if (up) oCOUNT <= oCOUNT + 1'b1;
    else if (dn) oCOUNT <= oCOUNT - 1'b1;
  end

  // Clear wins over a same-cycle set of the sticky flags and over iERROR.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oOVERFLOW  <= 1'b0;
      oUNDERFLOW <= 1'b0;
      oERR_COUNT <= '0;
    end else if (iCLEAR) begin
      oOVERFLOW  <= 1'b0;
      oUNDERFLOW <= 1'b0;
      oERR_COUNT <= '0;
    end else begin
      if (ovfSet) oOVERFLOW  <= 1'b1;
      if (unfSet) oUNDERFLOW <= 1'b1;
      if (iERROR && oERR_COUNT != ERR_MAX) oERR_COUNT <= oERR_COUNT + 1'b1;
    end
  end

  // BCD chain stepped by the same up/dn as the binary count, so the two
  // stay in lock-step. A digit steps when every lower digit wraps.
  logic [2:0] inc, dec;
  assign inc[0] = up;
  assign dec[0] = dn;

  for (genvar g = 0; g < 3; g++) begin : gDigit
    bcdDigit uDigit (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .iInc   (inc[g]),
      .iDec   (dec[g]),
      .oDigit (oBCD[4*g +: 4])
    );
    if (g < 2) begin : gChain
      assign inc[g+1] = inc[g] & (oBCD[4*g +: 4] == 4'd9);
      assign dec[g+1] = dec[g] & (oBCD[4*g +: 4] == 4'd0);
    end
  end
endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Directed bench for parking_lot_occupancy. Instance A uses the default
// parameters; instance B is a small lot (CAPACITY 12, ERR_W 2, threshold 2)
// for the full/overflow and error-saturation corners.
module tb_parking_lot_occupancy;
  logic iCLK = 1'b0;
  logic iRESET = 1'b1;
  always #5 iCLK = ~iCLK;

  logic aEnter = 0, aExit = 0, aError = 0, aClear = 0;
  logic [7:0]  aCount;
  logic [11:0] aBcd;
  logic aFull, aEmpty, aOvf, aUnf, aAlarm;
  logic [7:0]  aErr;

  logic bEnter = 0, bExit = 0, bError = 0, bClear = 0;
  logic [3:0]  bCount;
  logic [11:0] bBcd;
  logic bFull, bEmpty, bOvf, bUnf, bAlarm;
  logic [1:0]  bErr;

  parking_lot_occupancy uDutA (
    .iCLK(iCLK), .iRESET(iRESET), .iENTER(aEnter), .iEXIT(aExit),
    .iERROR(aError), .iCLEAR(aClear), .oCOUNT(aCount), .oBCD(aBcd),
    .oFULL(aFull), .oEMPTY(aEmpty), .oOVERFLOW(aOvf), .oUNDERFLOW(aUnf),
    .oERR_COUNT(aErr), .oALARM(aAlarm)
  );

  parking_lot_occupancy #(.CAPACITY(12), .CW(4), .ERR_W(2), .ERR_THRESH(2)) uDutB (
    .iCLK(iCLK), .iRESET(iRESET), .iENTER(bEnter), .iEXIT(bExit),
    .iERROR(bError), .iCLEAR(bClear), .oCOUNT(bCount), .oBCD(bBcd),
    .oFULL(bFull), .oEMPTY(bEmpty), .oOVERFLOW(bOvf), .oUNDERFLOW(bUnf),
    .oERR_COUNT(bErr), .oALARM(bAlarm)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses on A, sample #1 after the edge.
  task automatic stepA(input logic en, input logic ex, input logic er, input logic cl);
    aEnter = en; aExit = ex; aError = er; aClear = cl;
    @(posedge iCLK); #1;
    aEnter = 0; aExit = 0; aError = 0; aClear = 0;
  endtask

  task automatic stepB(input logic en, input logic ex, input logic er, input logic cl);
    bEnter = en; bExit = ex; bError = er; bClear = cl;
    @(posedge iCLK); #1;
    bEnter = 0; bExit = 0; bError = 0; bClear = 0;
  endtask

  task automatic chkA(input string tag, input int cnt, input int bcd,
                      input int full, input int empty);
    chk({tag, ".count"}, int'(aCount), cnt);
    chk({tag, ".bcd"},   int'(aBcd),   bcd);
    chk({tag, ".full"},  int'(aFull),  full);
    chk({tag, ".empty"}, int'(aEmpty), empty);
  endtask

  task automatic chkAReset(input string tag);
    chkA(tag, 0, 'h000, 0, 1);
    chk({tag, ".ovf"},   int'(aOvf),   0);
    chk({tag, ".unf"},   int'(aUnf),   0);
    chk({tag, ".err"},   int'(aErr),   0);
    chk({tag, ".alarm"}, int'(aAlarm), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    chkAReset("rst");
    chk("rstB.count", int'(bCount), 0);
    chk("rstB.empty", int'(bEmpty), 1);
    iRESET = 1'b0;

    // 3 enters
    repeat (3) stepA(1, 0, 0, 0);
    chkA("enter3", 3, 'h003, 0, 0);

    // 9 -> 10 carry across ones
    repeat (6) stepA(1, 0, 0, 0);
    chkA("at9", 9, 'h009, 0, 0);
    stepA(1, 0, 0, 0);
    chkA("carry10", 10, 'h010, 0, 0);

    // up to 100, then borrow through two digits
    repeat (90) stepA(1, 0, 0, 0);
    chkA("carry100", 100, 'h100, 0, 0);
    stepA(0, 1, 0, 0);
    chkA("borrow99", 99, 'h099, 0, 0);

    // 11 on A: hold, no flags
    stepA(1, 1, 0, 0);
    chkA("both99", 99, 'h099, 0, 0);

    // Error counter and alarm threshold on A (error alongside enter)
    repeat (3) stepA(0, 0, 1, 0);
    chk("err3", int'(aErr), 3);
    chk("alarm3", int'(aAlarm), 0);
    stepA(1, 0, 1, 0);
    chk("err4", int'(aErr), 4);
    chk("alarm4", int'(aAlarm), 1);
    chkA("errEnter", 100, 'h100, 0, 0);
    stepA(0, 0, 1, 1);
    chk("clrErr", int'(aErr), 0);
    chk("clrAlarm", int'(aAlarm), 0);

    // B: underflow at empty, then clear
    stepB(0, 1, 0, 0);
    chk("unf.count", int'(bCount), 0);
    chk("unf.flag", int'(bUnf), 1);
    chk("unf.empty", int'(bEmpty), 1);
    stepB(0, 0, 0, 1);
    chk("unfClr.flag", int'(bUnf), 0);
    stepB(1, 1, 0, 0);
    chk("bothEmpty.count", int'(bCount), 0);
    chk("bothEmpty.unf", int'(bUnf), 0);
    chk("bothEmpty.ovf", int'(bOvf), 0);

    // B: fill to capacity, overflow
    repeat (12) stepB(1, 0, 0, 0);
    chk("full.count", int'(bCount), 12);
    chk("full.bcd", int'(bBcd), 'h012);
    chk("full.full", int'(bFull), 1);
    chk("full.ovf", int'(bOvf), 0);
    stepB(1, 0, 0, 0);
    chk("ovf.count", int'(bCount), 12);
    chk("ovf.flag", int'(bOvf), 1);
    stepB(0, 1, 0, 0);
    chk("ovfExit.count", int'(bCount), 11);
    chk("ovfExit.bcd", int'(bBcd), 'h011);
    chk("ovfExit.flag", int'(bOvf), 1);
    chk("ovfExit.full", int'(bFull), 0);
    stepB(1, 0, 0, 0);
    stepB(0, 0, 0, 1);
    chk("ovfClr.flag", int'(bOvf), 0);
    chk("ovfClr.count", int'(bCount), 12);
    stepB(1, 1, 0, 0);
    chk("bothFull.count", int'(bCount), 12);
    chk("bothFull.ovf", int'(bOvf), 0);
    // clear beats a same-cycle overflow set
    stepB(1, 0, 0, 1);
    chk("clrVsOvf.flag", int'(bOvf), 0);
    chk("clrVsOvf.count", int'(bCount), 12);
    // clear does not block occupancy update
    stepB(0, 1, 0, 1);
    chk("clrExit.count", int'(bCount), 11);

    // B: error saturation at 2**2-1
    stepB(0, 0, 1, 0);
    chk("errB1.alarm", int'(bAlarm), 0);
    repeat (4) stepB(0, 0, 1, 0);
    chk("errSat.count", int'(bErr), 3);
    chk("errSat.alarm", int'(bAlarm), 1);
    stepB(0, 0, 1, 1);
    chk("clrVsErr.count", int'(bErr), 0);

    // A: async reset mid-burst at 57
    iRESET = 1'b1;
    #1;
    iRESET = 1'b0;
    repeat (57) stepA(1, 0, 0, 0);
    chkA("at57", 57, 'h057, 0, 0);
    aEnter = 1'b1;
    #2;
    iRESET = 1'b1;
    #1;
    chkAReset("midRst");
    @(posedge iCLK); #1;
    chkAReset("rstHeld");
    iRESET = 1'b0;
    aEnter = 1'b0;
    stepA(1, 0, 0, 0);
    chkA("resume", 1, 'h001, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
